// File: rtl/chick_pkg.sv
// Shared types and constants for the Chicken Cha-Cha-Cha turn controller:
// tile symbol table, FSM state encoding and player-count decode.
package chick_pkg;

  localparam int NUM_TILES_DEF = 24;
  localparam int TILE_COUNT    = 24;

  // sym(i) = (i*3 + i/8) mod 8, so each of the 8 symbols appears exactly 3 times.
  localparam logic [2:0] TILE_SYM [0:TILE_COUNT-1] = '{
    3'd0, 3'd3, 3'd6, 3'd1, 3'd4, 3'd7, 3'd2, 3'd5,
    3'd1, 3'd4, 3'd7, 3'd2, 3'd5, 3'd0, 3'd3, 3'd6,
    3'd2, 3'd5, 3'd0, 3'd3, 3'd6, 3'd1, 3'd4, 3'd7
  };

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CARD = 3'd1,
    S_LOOKUP    = 3'd2,
    S_STEP      = 3'd3,
    S_PASS      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  function automatic logic [2:0] player_count(input logic [1:0] n);
    case (n)
      2'd0:    return 3'd2;
      2'd1:    return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/chick_tile_rom.sv
// Combinational tile-symbol lookup; positions outside the ring read as symbol 0.
module chick_tile_rom
  import chick_pkg::*;
(
  input  logic [4:0] pos,
  output logic [2:0] sym
);

  always_comb begin
    sym = 3'd0;
    if (pos < 5'(TILE_COUNT)) sym = TILE_SYM[pos];
  end

endmodule

// File: rtl/chick_turn_ctrl.sv
// Turn controller: decides step or pass for each flipped card, drives one-hot
// step strobes to the position counters, counts steps and declares the winner.
module chick_turn_ctrl
  import chick_pkg::*;
#(
  parameter int NUM_TILES = NUM_TILES_DEF,
  parameter int WIN_STEPS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] N,
  input  logic [4:0] p1_cnt,
  input  logic [4:0] p2_cnt,
  input  logic [4:0] p3_cnt,
  input  logic [4:0] p4_cnt,
  input  logic       card_valid,
  input  logic [2:0] card_sym,
  output logic       card_ready,
  output logic [3:0] p_da,
  output logic [1:0] turn,
  output logic       winner_valid,
  output logic [1:0] winner,
  output logic [2:0] state_dbg
);

  // Card handshake: a card is consumed on a rising edge where card_valid and
  // card_ready are both high; card_ready is high only in WAIT_CARD, and a
  // card_valid seen at any other time is dropped, never queued.

  state_t     state;
  logic [2:0] players;
  logic [2:0] sym_q;
  logic [4:0] step_cnt [4];

  logic [4:0] cur_pos, eff_pos, next_pos, step_inc;
  logic [2:0] tile, turn_inc;
  logic [1:0] turn_adv;
  logic       match;

  always_comb begin
    case (turn)
      2'd0:    cur_pos = p1_cnt;
      2'd1:    cur_pos = p2_cnt;
      2'd2:    cur_pos = p3_cnt;
      default: cur_pos = p4_cnt;
    endcase
    eff_pos  = (cur_pos >= 5'(NUM_TILES)) ? 5'd0 : cur_pos;
    next_pos = (eff_pos == 5'(NUM_TILES - 1)) ? 5'd0 : eff_pos + 5'd1;
    step_inc = (step_cnt[turn] == 5'd31) ? 5'd31 : step_cnt[turn] + 5'd1;
    turn_inc = {1'b0, turn} + 3'd1;
    turn_adv = (turn_inc == players) ? 2'd0 : turn_inc[1:0];
  end

  chick_tile_rom u_rom (
    .pos (next_pos),
    .sym (tile)
  );

  assign match     = (tile == sym_q);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      card_ready   <= 1'b0;
      p_da         <= 4'b0000;
      turn         <= 2'd0;
      winner_valid <= 1'b0;
      winner       <= 2'd0;
      players      <= 3'd2;
      sym_q        <= 3'd0;
      for (int k = 0; k < 4; k++) step_cnt[k] <= 5'd0;
    end else begin
      // Strobe defaults low so it is exactly one cycle wide.
      p_da <= 4'b0000;
      case (state)
        S_IDLE: begin
          if (start) begin
            players    <= player_count(N);
            turn       <= 2'd0;
            card_ready <= 1'b1;
            state      <= S_WAIT_CARD;
            for (int k = 0; k < 4; k++) step_cnt[k] <= 5'd0;
          end
        end
        S_WAIT_CARD: begin
          if (card_valid) begin
            sym_q      <= card_sym;
            card_ready <= 1'b0;
            state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (match) begin
            p_da  <= 4'b0001 << turn;
            state <= S_STEP;
          end else begin
            state <= S_PASS;
          end
        end
        S_STEP: begin
          step_cnt[turn] <= step_inc;
          if (step_inc == 5'(WIN_STEPS)) begin
            winner_valid <= 1'b1;
            winner       <= turn;
            state        <= S_DONE;
          end else begin
            card_ready <= 1'b1;
            state      <= S_WAIT_CARD;
          end
        end
        S_PASS: begin
          turn       <= turn_adv;
          card_ready <= 1'b1;
          state      <= S_WAIT_CARD;
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chick_turn_ctrl.sv
// Bench for chick_turn_ctrl: behavioural game model feeds an expected queue,
// a negedge monitor checks each consumed card's outcome, plus directed cases.
module tb_chick_turn_ctrl;
  import chick_pkg::*;

  localparam int WIN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] n_sel = 2'd0;
  logic       card_valid = 1'b0;
  logic [2:0] card_sym = 3'd0;
  logic       card_ready;
  logic [3:0] p_da;
  logic [1:0] turn;
  logic       winner_valid;
  logic [1:0] winner;
  logic [2:0] state_dbg;

  logic [4:0] pos_q [4];
  logic [4:0] pos_load_val [4];
  logic       pos_load = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_pos [4];
  int m_steps [4];
  int m_turn, m_players, m_winner;
  bit m_done;

  logic [8:0] exp_q [$];
  logic [8:0] cur_exp;
  int  stage = 0;
  bit  mon_en = 1'b1;

  chick_turn_ctrl #(.NUM_TILES(24), .WIN_STEPS(WIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .N            (n_sel),
    .p1_cnt       (pos_q[0]),
    .p2_cnt       (pos_q[1]),
    .p3_cnt       (pos_q[2]),
    .p4_cnt       (pos_q[3]),
    .card_valid   (card_valid),
    .card_sym     (card_sym),
    .card_ready   (card_ready),
    .p_da         (p_da),
    .turn         (turn),
    .winner_valid (winner_valid),
    .winner       (winner),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic int ring_next(input int p);
    int e;
    e = (p >= 24) ? 0 : p;
    return (e + 1) % 24;
  endfunction

  function automatic int sym_of(input int i);
    return (i * 3 + i / 8) % 8;
  endfunction

  // Position counters consuming p_da
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (pos_load) pos_q[k] <= pos_load_val[k];
      else if (p_da[k]) pos_q[k] <= 5'(ring_next(int'(pos_q[k])));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!mon_en) begin
      stage = 0;
    end else begin
      if (stage == 1) begin
        chk("lookup_p_da", int'(p_da), 0);
        chk("lookup_card_ready", int'(card_ready), 0);
        stage = 2;
      end else if (stage == 2) begin
        chk("strobe_p_da", int'(p_da), int'(cur_exp[8:5]));
        chk("busy_card_ready", int'(card_ready), 0);
        stage = 3;
      end else if (stage == 3) begin
        chk("post_p_da", int'(p_da), 0);
        chk("turn", int'(turn), int'(cur_exp[4:3]));
        chk("card_ready_back", int'(card_ready), cur_exp[2] ? 0 : 1);
        chk("winner_valid", int'(winner_valid), int'(cur_exp[2]));
        if (cur_exp[2]) chk("winner", int'(winner), int'(cur_exp[1:0]));
        stage = 0;
      end
      if (stage == 0 && card_ready && card_valid && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept actual=accepted expected=none");
        end else begin
          cur_exp = exp_q.pop_front();
          stage = 1;
        end
      end
    end
  end

  // Driver tasks (all enter and leave at posedge + #1)
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_positions(input int a, input int b, input int c, input int d);
    pos_load_val[0] = 5'(a); pos_load_val[1] = 5'(b);
    pos_load_val[2] = 5'(c); pos_load_val[3] = 5'(d);
    m_pos[0] = a; m_pos[1] = b; m_pos[2] = c; m_pos[3] = d;
    pos_load = 1'b1;
    @(posedge clk); #1;
    pos_load = 1'b0;
  endtask

  task automatic start_game(input int n, input bit with_card);
    n_sel = 2'(n);
    start = 1'b1;
    card_valid = with_card;
    card_sym = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    start = 1'b0;
    card_valid = 1'b0;
    m_players = (n == 0) ? 2 : (n == 1) ? 3 : 4;
    m_turn = 0;
    m_done = 1'b0;
    m_winner = 0;
    foreach (m_steps[k]) m_steps[k] = 0;
    if (with_card) begin
      @(negedge clk);
      chk("start_only_state", int'(state_dbg), int'(S_WAIT_CARD));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_card(input bit want_match, input int hold, input bit push);
    int waited;
    int np;
    int s;
    logic [3:0] epda;
    waited = 0;
    while (!card_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!card_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
      return;
    end
    np = ring_next(m_pos[m_turn]);
    s = want_match ? sym_of(np) : (sym_of(np) + int'($urandom_range(1, 7))) % 8;
    card_sym = 3'(s);
    card_valid = 1'b1;
    if (push) begin
      if (sym_of(np) == s) begin
        epda = 4'(1 << m_turn);
        m_pos[m_turn] = np;
        if (m_steps[m_turn] < 31) m_steps[m_turn]++;
        if (m_steps[m_turn] == WIN) begin
          m_done = 1'b1;
          m_winner = m_turn;
        end
      end else begin
        epda = 4'b0000;
        m_turn = (m_turn + 1) % m_players;
      end
      exp_q.push_back({epda, 2'(m_turn), m_done, 2'(m_winner)});
    end
    @(posedge clk); #1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    card_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((stage != 0 || exp_q.size() != 0) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_pending", exp_q.size() + stage, 0);
  endtask

  task automatic poke_done();
    card_valid = 1'b1;
    card_sym = 3'($urandom_range(0, 7));
    repeat (3) begin
      @(negedge clk);
      chk("done_p_da", int'(p_da), 0);
      chk("done_card_ready", int'(card_ready), 0);
      chk("done_winner_valid", int'(winner_valid), 1);
      chk("done_winner", int'(winner), m_winner);
      @(posedge clk); #1;
    end
    card_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    foreach (pos_q[k]) pos_load_val[k] = 5'd0;
    do_reset();
    @(negedge clk);
    chk("rst_state", int'(state_dbg), int'(S_IDLE));
    chk("rst_card_ready", int'(card_ready), 0);
    chk("rst_p_da", int'(p_da), 0);
    chk("rst_turn", int'(turn), 0);
    chk("rst_winner_valid", int'(winner_valid), 0);
    chk("rst_winner", int'(winner), 0);
    @(posedge clk); #1;

    // First match for player 0, start and card_valid together
    load_positions(0, 0, 0, 0);
    start_game(0, 1'b1);
    send_card(1'b1, 0, 1'b1);
    drain();

    // Three mismatches with 3 players: turn 1, 2, 0
    do_reset();
    load_positions(0, 0, 0, 0);
    start_game(1, 1'b0);
    repeat (3) send_card(1'b0, 0, 1'b1);
    drain();

    // Player 2 at position 23 wraps to tile 0
    do_reset();
    load_positions(0, 23, 0, 0);
    start_game(2, 1'b0);
    send_card(1'b0, 0, 1'b1);
    send_card(1'b1, 0, 1'b1);
    drain();

    // Three matches win, later cards ignored
    do_reset();
    load_positions(5, 0, 0, 0);
    start_game(0, 1'b0);
    repeat (3) send_card(1'b1, 0, 1'b1);
    drain();
    poke_done();

    // card_valid held through LOOKUP and STEP
    do_reset();
    load_positions(10, 3, 0, 0);
    start_game(0, 1'b0);
    send_card(1'b1, 2, 1'b1);
    send_card(1'b0, 0, 1'b1);
    drain();

    // Reset during STEP
    do_reset();
    load_positions(0, 0, 0, 0);
    start_game(0, 1'b0);
    mon_en = 1'b0;
    send_card(1'b1, 0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("step_p_da", int'(p_da), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cut_p_da", int'(p_da), 0);
    chk("cut_state", int'(state_dbg), int'(S_IDLE));
    chk("cut_turn", int'(turn), 0);
    @(posedge clk); #1;
    card_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_accept_state", int'(state_dbg), int'(S_IDLE));
      chk("idle_card_ready", int'(card_ready), 0);
      @(posedge clk); #1;
    end
    card_valid = 1'b0;
    mon_en = 1'b1;
    load_positions(0, 0, 0, 0);
    start_game(0, 1'b0);
    send_card(1'b1, 0, 1'b1);
    drain();

    // Randomized games
    for (int g = 0; g < 10; g++) begin
      do_reset();
      load_positions(
        ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23)),
        ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23)),
        ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23)),
        ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23)));
      start_game(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 60 && !m_done; c++) begin
        send_card(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b1);
      end
      drain();
      if (m_done) poke_done();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
